// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
// Timing constants for an 800x480 panel at a 1056x525 total raster, plus the
// pixel helpers shared by the frame reader:
//   - rgb565_to_888 : bit-replicating RGB565 -> RGB888 expansion
//   - bar_of        : active column -> colour-bar index (100-pixel bars)
//   - bar_colour    : colour-bar index -> RGB888 colour
// The bar helpers are only used by the optional test-pattern build
// (LCD_TEST_PATTERN_EN).
package lcd_timing_pkg;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    // Horizontal timing, in pixel clocks
    localparam logic [H_CNT_W-1:0] H_SYNC      = 11'd128;
    localparam logic [H_CNT_W-1:0] H_BP        = 11'd88;
    localparam logic [H_CNT_W-1:0] H_ACT       = 11'd800;
    localparam logic [H_CNT_W-1:0] H_FP        = 11'd40;
    localparam logic [H_CNT_W-1:0] H_TOTAL     = 11'd1056;
    localparam logic [H_CNT_W-1:0] H_MAX       = 11'd1055;
    localparam logic [H_CNT_W-1:0] H_SYNC_END  = 11'd127;
    localparam logic [H_CNT_W-1:0] H_ACT_START = 11'd216;
    localparam logic [H_CNT_W-1:0] H_ACT_END   = 11'd1015;

    // Vertical timing, in lines
    localparam logic [V_CNT_W-1:0] V_SYNC      = 10'd2;
    localparam logic [V_CNT_W-1:0] V_BP        = 10'd33;
    localparam logic [V_CNT_W-1:0] V_ACT       = 10'd480;
    localparam logic [V_CNT_W-1:0] V_FP        = 10'd10;
    localparam logic [V_CNT_W-1:0] V_TOTAL     = 10'd525;
    localparam logic [V_CNT_W-1:0] V_MAX       = 10'd524;
    localparam logic [V_CNT_W-1:0] V_SYNC_END  = 10'd1;
    localparam logic [V_CNT_W-1:0] V_ACT_START = 10'd35;
    localparam logic [V_CNT_W-1:0] V_ACT_END   = 10'd514;
    // First front-porch line: the read port is re-armed here
    localparam logic [V_CNT_W-1:0] V_LOAD_LINE = 10'd515;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    // Replicate the top bits of each channel into the new LSBs so that
    // full-scale 565 maps to full-scale 888.
    function automatic rgb888_t rgb565_to_888(input logic [15:0] px);
        rgb888_t c;
        c.r = {px[15:11], px[15:13]};
        c.g = {px[10:5],  px[10:9]};
        c.b = {px[4:0],   px[4:2]};
        return c;
    endfunction

    // Column (0..799 inside the active area) to bar index
    function automatic bar_e bar_of(input logic [H_CNT_W-1:0] x);
        bar_e bar;
        if (x < 11'd100)      bar = BAR_WHITE;
        else if (x < 11'd200) bar = BAR_YELLOW;
        else if (x < 11'd300) bar = BAR_CYAN;
        else if (x < 11'd400) bar = BAR_GREEN;
        else if (x < 11'd500) bar = BAR_MAGENTA;
        else if (x < 11'd600) bar = BAR_RED;
        else if (x < 11'd700) bar = BAR_BLUE;
        else                  bar = BAR_BLACK;
        return bar;
    endfunction

    function automatic rgb888_t bar_colour(input bar_e bar);
        rgb888_t c;
        case (bar)
            BAR_WHITE:   c = 24'hFFFFFF;
            BAR_YELLOW:  c = 24'hFFFF00;
            BAR_CYAN:    c = 24'h00FFFF;
            BAR_GREEN:   c = 24'h00FF00;
            BAR_MAGENTA: c = 24'hFF00FF;
            BAR_RED:     c = 24'hFF0000;
            BAR_BLUE:    c = 24'h0000FF;
            BAR_BLACK:   c = 24'h000000;
            default:     c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// lcd_sync_counter
// Raster position counters and their decode.
// Ports:
//   clk, rst_n  : pixel clock, async active-low reset
//   h_pos       : column relative to the first active pixel (only built with
//                 LCD_TEST_PATTERN_EN)
//   h_active    : horizontal active window (216..1015)
//   v_active    : vertical active window (35..514)
//   hsync       : high during horizontal sync (0..127)
//   vsync       : high during vertical sync (lines 0..1)
//   rearm       : single-cycle strobe at (h=0, v=515)
// Reset parks the counters at the re-arm point so a fresh read-port load
// follows every reset release.
module lcd_sync_counter
    import lcd_timing_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
`ifdef LCD_TEST_PATTERN_EN
    output logic [H_CNT_W-1:0] h_pos,
`endif
    output logic               h_active,
    output logic               v_active,
    output logic               hsync,
    output logic               vsync,
    output logic               rearm
);

    logic [H_CNT_W-1:0] h_cnt_r;
    logic [V_CNT_W-1:0] v_cnt_r;

    // Horizontal counter wraps each line and steps the vertical counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= V_LOAD_LINE;
        end else if (h_cnt_r == H_MAX) begin
            h_cnt_r <= 11'd0;
            if (v_cnt_r == V_MAX) begin
                v_cnt_r <= 10'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 10'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

    // Window and strobe decode straight from the counter registers
    always_comb begin
        h_active = 1'b0;
        v_active = 1'b0;
        hsync    = 1'b0;
        vsync    = 1'b0;
        rearm    = 1'b0;
        if ((h_cnt_r >= H_ACT_START) && (h_cnt_r <= H_ACT_END)) begin
            h_active = 1'b1;
        end else begin
            h_active = 1'b0;
        end
        if ((v_cnt_r >= V_ACT_START) && (v_cnt_r <= V_ACT_END)) begin
            v_active = 1'b1;
        end else begin
            v_active = 1'b0;
        end
        if (h_cnt_r <= H_SYNC_END) begin
            hsync = 1'b1;
        end else begin
            hsync = 1'b0;
        end
        if (v_cnt_r <= V_SYNC_END) begin
            vsync = 1'b1;
        end else begin
            vsync = 1'b0;
        end
        if ((h_cnt_r == 11'd0) && (v_cnt_r == V_LOAD_LINE)) begin
            rearm = 1'b1;
        end else begin
            rearm = 1'b0;
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    assign h_pos = h_cnt_r - H_ACT_START;
`endif

endmodule

// File: rtl/lcd_frame_reader.sv
// lcd_frame_reader
// Scans an 800x480 LCD frame, pulls RGB565 pixels from an SDRAM read FIFO
// and drives the panel. Re-arms the SDRAM read address once per frame at the
// start of vertical front porch, choosing between two frame buffers.
// Optional build macro: LCD_TEST_PATTERN_EN adds input TP_EN which replaces
// the pixel colour by eight 100-pixel colour bars (the FIFO is still drained
// exactly as in normal operation so the SDRAM address stays in step).
// Ports:
//   CLK, RESET_N          : pixel clock, async active-low reset
//   FRAME_SEL             : frame buffer select, sampled at re-arm
//   TP_EN                 : test-pattern enable (LCD_TEST_PATTERN_EN only)
//   RD_DATA, RD_EMPTY     : read-FIFO q (valid the cycle after RD) and empty
//   RD                    : read-FIFO read request
//   RD_LOAD               : address load / FIFO clear pulse, LOAD_CYCLES long
//   RD_ADDR, RD_LENGTH    : frame start address and burst length
//   LCD_R/G/B, LCD_DE     : pixel colour and data enable
//   LCD_HSYNC_N/VSYNC_N   : active-low syncs
//   FRAME_DONE            : one-cycle pulse at the end of the active frame
//   UNDERFLOW             : sticky, FIFO empty during an active read slot
// Every LCD output lags the raster counter by exactly two clocks.
module lcd_frame_reader
    import lcd_timing_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = 23'h000000,
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = 23'h100000,
    parameter logic [8:0]        BURST_LEN   = 9'd128,
    parameter logic [3:0]        LOAD_CYCLES = 4'd4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FRAME_SEL,
`ifdef LCD_TEST_PATTERN_EN
    input  logic              TP_EN,
`endif
    input  logic [15:0]       RD_DATA,
    input  logic              RD_EMPTY,
    output logic              RD,
    output logic              RD_LOAD,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic [8:0]        RD_LENGTH,
    output logic [7:0]        LCD_R,
    output logic [7:0]        LCD_G,
    output logic [7:0]        LCD_B,
    output logic              LCD_DE,
    output logic              LCD_HSYNC_N,
    output logic              LCD_VSYNC_N,
    output logic              FRAME_DONE,
    output logic              UNDERFLOW
);

    logic    h_active_s;
    logic    v_active_s;
    logic    hsync_s;
    logic    vsync_s;
    logic    rearm_s;
    logic    active_s;
    logic    rd_s;

    // Decode delayed by one clock, aligned with the FIFO q
    logic    act_d_r;
    logic    rd_d_r;
    logic    hsync_d_r;
    logic    vsync_d_r;

    logic    lcd_de_r;
    logic    lcd_hsync_n_r;
    logic    lcd_vsync_n_r;
    rgb888_t pixel_s;
    rgb888_t pixel_r;

    logic       rd_load_r;
    logic [3:0] load_cnt_r;
    logic       frame_sel_r;
    logic       frame_done_r;
    logic       underflow_r;

`ifdef LCD_TEST_PATTERN_EN
    logic [H_CNT_W-1:0] h_pos_s;
    bar_e               bar_d_r;
`endif

    lcd_sync_counter u_sync (
        .clk      (CLK),
        .rst_n    (RESET_N),
`ifdef LCD_TEST_PATTERN_EN
        .h_pos    (h_pos_s),
`endif
        .h_active (h_active_s),
        .v_active (v_active_s),
        .hsync    (hsync_s),
        .vsync    (vsync_s),
        .rearm    (rearm_s)
    );

    assign active_s = h_active_s & v_active_s;
    // Only read when a word is available; an empty slot becomes a black pixel
    assign rd_s     = active_s & ~RD_EMPTY;

    // First pipeline stage: hold the decode until the FIFO q is valid
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            act_d_r   <= 1'b0;
            rd_d_r    <= 1'b0;
            hsync_d_r <= 1'b0;
            vsync_d_r <= 1'b0;
        end else begin
            act_d_r   <= active_s;
            rd_d_r    <= rd_s;
            hsync_d_r <= hsync_s;
            vsync_d_r <= vsync_s;
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    // Bar index travels with the delayed decode
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bar_d_r <= BAR_WHITE;
        end else begin
            bar_d_r <= bar_of(h_pos_s);
        end
    end
`endif

    // Pixel colour for the second stage
    always_comb begin
        pixel_s = 24'h000000;
`ifdef LCD_TEST_PATTERN_EN
        if (act_d_r && TP_EN) begin
            pixel_s = bar_colour(bar_d_r);
        end else if (act_d_r && rd_d_r) begin
            pixel_s = rgb565_to_888(RD_DATA);
        end else begin
            pixel_s = 24'h000000;
        end
`else
        if (act_d_r && rd_d_r) begin
            pixel_s = rgb565_to_888(RD_DATA);
        end else begin
            pixel_s = 24'h000000;
        end
`endif
    end

    // Second pipeline stage: panel output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lcd_de_r      <= 1'b0;
            lcd_hsync_n_r <= 1'b1;
            lcd_vsync_n_r <= 1'b1;
            pixel_r       <= 24'h000000;
        end else begin
            lcd_de_r      <= act_d_r;
            lcd_hsync_n_r <= ~hsync_d_r;
            lcd_vsync_n_r <= ~vsync_d_r;
            pixel_r       <= pixel_s;
        end
    end

    // Per-frame re-arm: buffer select capture, load pulse and frame flags
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_load_r    <= 1'b0;
            load_cnt_r   <= 4'd0;
            frame_sel_r  <= 1'b0;
            frame_done_r <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            frame_done_r <= rearm_s;
            // load_cnt_r counts the remaining high cycles after the first
            if (rearm_s) begin
                frame_sel_r <= FRAME_SEL;
                rd_load_r   <= 1'b1;
                load_cnt_r  <= LOAD_CYCLES - 4'd1;
            end else if (load_cnt_r != 4'd0) begin
                rd_load_r   <= 1'b1;
                load_cnt_r  <= load_cnt_r - 4'd1;
            end else begin
                rd_load_r   <= 1'b0;
            end
            // Re-arm never coincides with an active cycle
            if (rearm_s) begin
                underflow_r <= 1'b0;
            end else if (active_s && RD_EMPTY) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign RD          = rd_s;
    assign RD_LOAD     = rd_load_r;
    assign RD_ADDR     = frame_sel_r ? FRAME_BASE1 : FRAME_BASE0;
    assign RD_LENGTH   = BURST_LEN;
    assign LCD_R       = pixel_r.r;
    assign LCD_G       = pixel_r.g;
    assign LCD_B       = pixel_r.b;
    assign LCD_DE      = lcd_de_r;
    assign LCD_HSYNC_N = lcd_hsync_n_r;
    assign LCD_VSYNC_N = lcd_vsync_n_r;
    assign FRAME_DONE  = frame_done_r;
    assign UNDERFLOW   = underflow_r;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb_lcd_frame_reader
// Directed bench for lcd_frame_reader. A small FIFO model returns the running
// read index as pixel data; the bench tracks the raster position itself from
// the reset release and compares against hand-computed values.
module tb_lcd_frame_reader;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        FRAME_SEL;
    logic        TP_EN;
    logic [15:0] RD_DATA;
    logic        RD_EMPTY;
    logic        RD;
    logic        RD_LOAD;
    logic [22:0] RD_ADDR;
    logic [8:0]  RD_LENGTH;
    logic [7:0]  LCD_R;
    logic [7:0]  LCD_G;
    logic [7:0]  LCD_B;
    logic        LCD_DE;
    logic        LCD_HSYNC_N;
    logic        LCD_VSYNC_N;
    logic        FRAME_DONE;
    logic        UNDERFLOW;

    int   n_vec = 0;
    int   n_err = 0;
    int   bh;
    int   bv;
    int   fifo_idx;
    logic rd_prev;

    always #5 CLK = ~CLK;

    lcd_frame_reader dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .FRAME_SEL   (FRAME_SEL),
`ifdef LCD_TEST_PATTERN_EN
        .TP_EN       (TP_EN),
`endif
        .RD_DATA     (RD_DATA),
        .RD_EMPTY    (RD_EMPTY),
        .RD          (RD),
        .RD_LOAD     (RD_LOAD),
        .RD_ADDR     (RD_ADDR),
        .RD_LENGTH   (RD_LENGTH),
        .LCD_R       (LCD_R),
        .LCD_G       (LCD_G),
        .LCD_B       (LCD_B),
        .LCD_DE      (LCD_DE),
        .LCD_HSYNC_N (LCD_HSYNC_N),
        .LCD_VSYNC_N (LCD_VSYNC_N),
        .FRAME_DONE  (FRAME_DONE),
        .UNDERFLOW   (UNDERFLOW)
    );

    // One clock: note RD before the edge, feed the FIFO word after it and
    // advance the bench's own raster position.
    task automatic tick();
        #1;
        rd_prev = RD;
        @(posedge CLK);
        #1;
        if (rd_prev) begin
            RD_DATA  = fifo_idx[15:0];
            fifo_idx = fifo_idx + 1;
        end
        bh = bh + 1;
        if (bh == 1056) begin
            bh = 0;
            bv = bv + 1;
            if (bv == 525) bv = 0;
        end
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        FRAME_SEL = 1'b1;
        TP_EN     = 1'b0;
        RD_EMPTY  = 1'b0;
        RD_DATA   = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++; if (RD !== 1'b0) begin n_err++; $display("FAIL reset_rd got %b want 0", RD); end
        n_vec++; if (RD_LOAD !== 1'b0) begin n_err++; $display("FAIL reset_rd_load got %b want 0", RD_LOAD); end
        n_vec++; if (RD_ADDR !== 23'h000000) begin n_err++; $display("FAIL reset_rd_addr got %h want 000000", RD_ADDR); end
        n_vec++; if (RD_LENGTH !== 9'd128) begin n_err++; $display("FAIL rd_length got %0d want 128", RD_LENGTH); end
        n_vec++; if ({LCD_R, LCD_G, LCD_B} !== 24'h000000) begin n_err++; $display("FAIL reset_rgb got %h want 000000", {LCD_R, LCD_G, LCD_B}); end
        n_vec++; if (LCD_DE !== 1'b0) begin n_err++; $display("FAIL reset_de got %b want 0", LCD_DE); end
        n_vec++; if ({LCD_HSYNC_N, LCD_VSYNC_N} !== 2'b11) begin n_err++; $display("FAIL reset_syncs got %b want 11", {LCD_HSYNC_N, LCD_VSYNC_N}); end
        n_vec++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", FRAME_DONE); end
        n_vec++; if (UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_underflow got %b want 0", UNDERFLOW); end
    endtask

    // Release with FRAME_SEL=1: load pulse of 4 clocks starting on the first
    // edge, one FRAME_DONE, buffer 1 address; FRAME_SEL then drops mid-frame.
    task automatic test_rearm();
        logic exp_load;
        logic exp_done;
        RESET_N  = 1'b1;
        bh       = 0;
        bv       = 515;
        fifo_idx = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_load = (k <= 4);
            exp_done = (k == 1);
            n_vec++; if (RD_LOAD !== exp_load) begin n_err++; $display("FAIL rearm_load_k%0d got %b want %b", k, RD_LOAD, exp_load); end
            n_vec++; if (FRAME_DONE !== exp_done) begin n_err++; $display("FAIL rearm_done_k%0d got %b want %b", k, FRAME_DONE, exp_done); end
            if (k == 1) begin
                n_vec++; if (RD_ADDR !== 23'h100000) begin n_err++; $display("FAIL rearm_addr got %h want 100000", RD_ADDR); end
                FRAME_SEL = 1'b0;
            end
        end
    endtask

    // Blanking lead-in, then the first active line with an always-full FIFO
    task automatic test_stream();
        int vs_low = 0;
        int rd_cnt = 0;
        int de_cnt = 0;
        int hs_low = 0;
        int first_de = -1;
        logic [23:0] p0, p1, p100, p799;
        p0 = 24'hxxxxxx; p1 = 24'hxxxxxx; p100 = 24'hxxxxxx; p799 = 24'hxxxxxx;
        while (!(bv == 35 && bh == 0)) begin
            tick();
            if (!LCD_VSYNC_N) vs_low++;
            if (rd_prev) rd_cnt++;
        end
        n_vec++; if (vs_low != 2112) begin n_err++; $display("FAIL vsync_low_cycles got %0d want 2112", vs_low); end
        n_vec++; if (rd_cnt != 0) begin n_err++; $display("FAIL blank_reads got %0d want 0", rd_cnt); end
        n_vec++; if (RD_ADDR !== 23'h100000) begin n_err++; $display("FAIL addr_after_sel_toggle got %h want 100000", RD_ADDR); end
        rd_cnt = 0;
        vs_low = 0;
        for (int i = 0; i < 1056; i++) begin
            tick();
            if (rd_prev) rd_cnt++;
            if (!LCD_HSYNC_N) hs_low++;
            if (!LCD_VSYNC_N) vs_low++;
            if (LCD_DE) begin
                de_cnt++;
                if (first_de < 0) first_de = bh;
                if (bh - 218 == 0)   p0   = {LCD_R, LCD_G, LCD_B};
                if (bh - 218 == 1)   p1   = {LCD_R, LCD_G, LCD_B};
                if (bh - 218 == 100) p100 = {LCD_R, LCD_G, LCD_B};
                if (bh - 218 == 799) p799 = {LCD_R, LCD_G, LCD_B};
            end
        end
        n_vec++; if (de_cnt != 800) begin n_err++; $display("FAIL de_per_line got %0d want 800", de_cnt); end
        n_vec++; if (first_de != 218) begin n_err++; $display("FAIL first_de_h got %0d want 218", first_de); end
        n_vec++; if (hs_low != 128) begin n_err++; $display("FAIL hsync_low got %0d want 128", hs_low); end
        n_vec++; if (vs_low != 0) begin n_err++; $display("FAIL vsync_active_line got %0d want 0", vs_low); end
        n_vec++; if (rd_cnt != 800) begin n_err++; $display("FAIL reads_per_line got %0d want 800", rd_cnt); end
        n_vec++; if (p0 !== 24'h000000) begin n_err++; $display("FAIL pixel0 got %h want 000000", p0); end
        n_vec++; if (p1 !== 24'h000008) begin n_err++; $display("FAIL pixel1 got %h want 000008", p1); end
        n_vec++; if (p100 !== 24'h000C21) begin n_err++; $display("FAIL pixel100 got %h want 000c21", p100); end
        n_vec++; if (p799 !== 24'h0061FF) begin n_err++; $display("FAIL pixel799 got %h want 0061ff", p799); end
    endtask

    // Line 36: FIFO empty for h=300..302 -> no reads, three black pixels
    task automatic test_underflow();
        int rd_cnt = 0;
        int rd_in_empty = 0;
        int cur_h;
        logic uf_before;
        logic [23:0] p83, p84, p85, p86, p87;
        uf_before = 1'bx;
        p83 = 24'hxxxxxx; p84 = 24'hxxxxxx; p85 = 24'hxxxxxx; p86 = 24'hxxxxxx; p87 = 24'hxxxxxx;
        for (int i = 0; i < 1056; i++) begin
            cur_h = bh;
            RD_EMPTY = (cur_h >= 300 && cur_h <= 302);
            if (cur_h == 300) uf_before = UNDERFLOW;
            tick();
            if (rd_prev) rd_cnt++;
            if (rd_prev && cur_h >= 300 && cur_h <= 302) rd_in_empty++;
            if (LCD_DE) begin
                if (bh - 218 == 83) p83 = {LCD_R, LCD_G, LCD_B};
                if (bh - 218 == 84) p84 = {LCD_R, LCD_G, LCD_B};
                if (bh - 218 == 85) p85 = {LCD_R, LCD_G, LCD_B};
                if (bh - 218 == 86) p86 = {LCD_R, LCD_G, LCD_B};
                if (bh - 218 == 87) p87 = {LCD_R, LCD_G, LCD_B};
            end
        end
        RD_EMPTY = 1'b0;
        n_vec++; if (uf_before !== 1'b0) begin n_err++; $display("FAIL underflow_before got %b want 0", uf_before); end
        n_vec++; if (rd_in_empty != 0) begin n_err++; $display("FAIL rd_while_empty got %0d want 0", rd_in_empty); end
        n_vec++; if (rd_cnt != 797) begin n_err++; $display("FAIL reads_line36 got %0d want 797", rd_cnt); end
        n_vec++; if (p83 !== 24'h006D9C) begin n_err++; $display("FAIL pixel83 got %h want 006d9c", p83); end
        n_vec++; if ({p84, p85, p86} !== 72'h0) begin n_err++; $display("FAIL black_pixels got %h want 0", {p84, p85, p86}); end
        n_vec++; if (p87 !== 24'h006DA5) begin n_err++; $display("FAIL pixel87 got %h want 006da5", p87); end
        n_vec++; if (UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL underflow_sticky got %b want 1", UNDERFLOW); end
    endtask

`ifdef LCD_TEST_PATTERN_EN
    // Line 37 with TP_EN: bar colours while the FIFO keeps draining
    task automatic test_pattern();
        int rd_cnt = 0;
        logic [23:0] p50, p150;
        p50 = 24'hxxxxxx; p150 = 24'hxxxxxx;
        TP_EN = 1'b1;
        while (bh != 370) begin
            tick();
            if (rd_prev) rd_cnt++;
            if (LCD_DE && bh - 218 == 50)  p50  = {LCD_R, LCD_G, LCD_B};
            if (LCD_DE && bh - 218 == 150) p150 = {LCD_R, LCD_G, LCD_B};
        end
        TP_EN = 1'b0;
        n_vec++; if (p50 !== 24'hFFFFFF) begin n_err++; $display("FAIL tp_pixel50 got %h want ffffff", p50); end
        n_vec++; if (p150 !== 24'hFFFF00) begin n_err++; $display("FAIL tp_pixel150 got %h want ffff00", p150); end
        n_vec++; if (rd_cnt != 154) begin n_err++; $display("FAIL tp_reads got %0d want 154", rd_cnt); end
    endtask
`endif

    // Reset at (h=500, v=37), then a fresh re-arm and a restart at v=515
    task automatic test_midframe_reset();
        int load_cnt = 0;
        int done_cnt = 0;
        int de_cnt = 0;
        int rd_cnt = 0;
        while (bh != 500) tick();
        n_vec++; if (LCD_DE !== 1'b1) begin n_err++; $display("FAIL pre_reset_de got %b want 1", LCD_DE); end
        n_vec++; if (UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL pre_reset_underflow got %b want 1", UNDERFLOW); end
        RESET_N = 1'b0;
        #1;
        n_vec++; if (LCD_DE !== 1'b0) begin n_err++; $display("FAIL mid_reset_de got %b want 0", LCD_DE); end
        n_vec++; if ({LCD_R, LCD_G, LCD_B} !== 24'h000000) begin n_err++; $display("FAIL mid_reset_rgb got %h want 000000", {LCD_R, LCD_G, LCD_B}); end
        n_vec++; if (UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL mid_reset_underflow got %b want 0", UNDERFLOW); end
        n_vec++; if (RD !== 1'b0) begin n_err++; $display("FAIL mid_reset_rd got %b want 0", RD); end
        n_vec++; if (RD_ADDR !== 23'h000000) begin n_err++; $display("FAIL mid_reset_addr got %h want 000000", RD_ADDR); end
        FRAME_SEL = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET_N  = 1'b1;
        bh       = 0;
        bv       = 515;
        fifo_idx = 0;
        RD_DATA  = 16'h0000;
        for (int k = 1; k <= 10562; k++) begin
            tick();
            if (RD_LOAD) load_cnt++;
            if (FRAME_DONE) done_cnt++;
            if (LCD_DE) de_cnt++;
            if (rd_prev) rd_cnt++;
            if (k == 1) begin
                n_vec++; if (RD_LOAD !== 1'b1) begin n_err++; $display("FAIL rerelease_load got %b want 1", RD_LOAD); end
                n_vec++; if (RD_ADDR !== 23'h100000) begin n_err++; $display("FAIL rerelease_addr got %h want 100000", RD_ADDR); end
                FRAME_SEL = 1'b0;
            end
            if (k == 10561) begin
                n_vec++; if (LCD_VSYNC_N !== 1'b1) begin n_err++; $display("FAIL vsync_before got %b want 1", LCD_VSYNC_N); end
            end
        end
        n_vec++; if (LCD_VSYNC_N !== 1'b0) begin n_err++; $display("FAIL vsync_restart got %b want 0", LCD_VSYNC_N); end
        n_vec++; if (load_cnt != 4) begin n_err++; $display("FAIL rerelease_load_len got %0d want 4", load_cnt); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL rerelease_done got %0d want 1", done_cnt); end
        n_vec++; if (de_cnt != 0 || rd_cnt != 0) begin n_err++; $display("FAIL blank_activity got de=%0d rd=%0d want 0/0", de_cnt, rd_cnt); end
        n_vec++; if (RD_ADDR !== 23'h100000) begin n_err++; $display("FAIL addr_hold got %h want 100000", RD_ADDR); end
        n_vec++; if (UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL underflow_after got %b want 0", UNDERFLOW); end
    endtask

    initial begin
        test_reset();
        test_rearm();
        test_stream();
        test_underflow();
`ifdef LCD_TEST_PATTERN_EN
        test_pattern();
`endif
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
